// File: rtl/cache_pkg.sv
// Shared cache definitions: line-fill FSM states, beat geometry and line type.
package cache_pkg;

  // Line-fill controller states; exposed on the debug port as well.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // One memory beat is a 64-bit little-endian word.
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_W     = 64;

  // Default line geometry (4 beats = 32 bytes = 256 bits).
  localparam int DEF_BEATS  = 4;
  localparam int DEF_LINE_W = DEF_BEATS * BEAT_W;

  typedef logic [DEF_LINE_W-1:0] line_t;

  // Bytes covered by one line of the given number of beats.
  function automatic int line_bytes(input int beats);
    return beats * BEAT_BYTES;
  endfunction

endpackage

// File: rtl/line_fill_ctrl_if.sv
// Bundle of the cache-side miss handshake and the Pmem read port.
// Handshakes:
//   miss_req/miss_ready : a miss is accepted on a posedge where both are 1;
//                         miss_req while miss_ready=0 is dropped, never queued.
//   fill_done/fill_err  : single-cycle pulse, no back-pressure; fill_line and
//                         fill_base stay stable until the next accepted miss.
//   mem_rd_en/mem_data_valid : one read outstanding at a time; mem_rd_en is a
//                         one-cycle pulse, the data beat is taken on the first
//                         cycle mem_data_valid=1 while the fill is waiting.
interface line_fill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
);
  logic                  miss_req;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  miss_ready;
  logic                  fill_done;
  logic                  fill_err;
  logic [ADDR_W-1:0]     fill_base;
  logic [BEATS*64-1:0]   fill_line;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [63:0]           mem_data;
  logic                  mem_data_valid;

  // The line-fill controller side.
  modport master (
    input  miss_req, miss_addr, mem_data, mem_data_valid,
    output miss_ready, fill_done, fill_err, fill_base, fill_line,
           mem_rd_en, mem_addr
  );

  // The environment side: cache controller plus physical memory.
  modport slave (
    output miss_req, miss_addr, mem_data, mem_data_valid,
    input  miss_ready, fill_done, fill_err, fill_base, fill_line,
           mem_rd_en, mem_addr
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// Line-fill controller: on an accepted miss, reads a whole cache line from Pmem
// one 64-bit beat at a time, critical word first with wrap inside the line,
// then pulses fill_done (with fill_err if a beat timed out).
module line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  line_fill_ctrl_if.master  bus,
  output fill_state_t       dbg_state_o
);

  localparam int LINE_BYTES = line_bytes(BEATS);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(BEATS);
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam int LINE_W     = BEATS * BEAT_W;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [IDX_W-1:0]  LAST_CNT = IDX_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_HIT  = TMO_W'(TIMEOUT);

  fill_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  base_q,  base_d;
  logic [IDX_W-1:0]   beat_q,  beat_d;   // slot currently being fetched
  logic [IDX_W-1:0]   cnt_q,   cnt_d;    // beats already completed
  logic [TMO_W-1:0]   tmo_q,   tmo_d;    // idle cycles spent in WAIT
  logic               err_q,   err_d;
  logic [LINE_W-1:0]  line_q,  line_d;

  // Register update; reset returns every register to zero / IDLE at once,
  // which also abandons any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      line_q  <= line_d;
    end
  end

  // Next-state and datapath decisions for the fill sequence.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    line_d  = line_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          // Byte-in-word bits are dropped; the word index picks the first beat.
          base_d  = bus.miss_addr & ~OFF_MASK;
          beat_d  = bus.miss_addr[OFF_W-1:3];
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        // Read is issued this cycle; data cannot be taken before WAIT.
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.mem_data_valid) begin
          line_d[{beat_q, 6'd0} +: BEAT_W] = bus.mem_data;
          // Index is IDX_W bits wide, so the increment wraps inside the line.
          beat_d = beat_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Give up on the whole line; unfetched slots keep older data.
          tmo_d   = TMO_HIT;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and take their reset values in the cycle after rst is sampled.
  assign bus.miss_ready = (state_q == IDLE);
  assign bus.fill_done  = (state_q == DONE);
  assign bus.fill_err   = (state_q == DONE) && err_q;
  assign bus.fill_base  = base_q;
  assign bus.fill_line  = line_q;
  assign bus.mem_rd_en  = (state_q == REQ);
  // base is line-aligned, so adding the beat offset never carries out of the line.
  assign bus.mem_addr   = base_q + ADDR_W'({beat_q, 3'b000});
  assign dbg_state_o    = state_q;

endmodule
